// File: rtl/prach_tdm_pack_if.sv
// Input sample stream for the PRACH TDM framer: 3-CC I/Q with frame marker and valid/ready.
interface prach_tdm_pack_if;
  logic [2:0][15:0] din_dr;
  logic [2:0][15:0] din_di;
  logic             din_sof;
  logic             din_valid;
  logic             din_ready;

  modport master (output din_dr, output din_di, output din_sof, output din_valid, input din_ready);
  modport slave  (input din_dr, input din_di, input din_sof, input din_valid, output din_ready);
endinterface

// File: rtl/prach_tdm_pack.sv
// 3-CC PRACH TDM framer: buffers input samples and launches one per 8-tick slot.
//
// state  | meaning
// S_FILL | waiting for PREFILL entries; slots launch zeros, no underflow flag
// S_RUN  | one entry popped per slot; empty FIFO at a slot flags underflow, back to S_FILL
module prach_tdm_pack #(
  parameter int FIFO_AW = 3,
  parameter int PREFILL = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  prach_tdm_pack_if.slave      din,
  input  logic                 clr_status,
  output logic [15:0]          dout_dr_cc0,
  output logic [15:0]          dout_dr_cc1,
  output logic [15:0]          dout_dr_cc2,
  output logic [15:0]          dout_di_cc0,
  output logic [15:0]          dout_di_cc1,
  output logic [15:0]          dout_di_cc2,
  output logic [2:0]           dout_chn,
  output logic                 sync_out,
  output logic                 underflow,
  output logic                 overflow,
  output logic [FIFO_AW:0]     fifo_level
);

  localparam int              DEPTH     = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_L   = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0] PREFILL_L = (FIFO_AW+1)'(PREFILL);

  typedef struct packed {
    logic             sof;
    logic [2:0][15:0] dr;
    logic [2:0][15:0] di;
  } entry_t;

  typedef enum logic {S_FILL, S_RUN} state_t;

  entry_t           mem [DEPTH];
  entry_t           head;
  entry_t           launch_q;
  logic [FIFO_AW:0] wr_ptr;
  logic [FIFO_AW:0] rd_ptr;
  logic [FIFO_AW:0] level;
  logic             wr_en;
  logic             slot_end;
  logic             pop;
  logic             ufl_set;
  logic             ofl_set;
  state_t           state_q;
  state_t           state_d;

  assign level          = wr_ptr - rd_ptr;
  assign fifo_level     = level;
  // Ready is forced low while reset is held so no write can race the release.
  assign din.din_ready  = !rst && (level < DEPTH_L);
  assign wr_en          = din.din_valid && din.din_ready;
  assign ofl_set        = din.din_valid && !din.din_ready;
  assign head           = mem[rd_ptr[FIFO_AW-1:0]];
  assign slot_end       = (dout_chn == 3'd7);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[FIFO_AW-1:0]] <= '{sof: din.din_sof, dr: din.din_dr, di: din.din_di};
    end
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    ufl_set = 1'b0;
    if (slot_end) begin
      case (state_q)
        S_FILL: begin
          if (level >= PREFILL_L) begin
            pop     = 1'b1;
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          if (level != '0) begin
            pop = 1'b1;
          end else begin
            ufl_set = 1'b1;
            state_d = S_FILL;
          end
        end
        default: state_d = S_FILL;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FILL;
      dout_chn  <= 3'd0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      launch_q  <= '0;
      sync_out  <= 1'b0;
      underflow <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state_q  <= state_d;
      dout_chn <= dout_chn + 3'd1;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (slot_end) begin
        launch_q <= pop ? head : '0;
        sync_out <= pop && head.sof;
      end else begin
        sync_out <= 1'b0;
      end
      // A set event in the same cycle wins over the clear.
      if (ufl_set)         underflow <= 1'b1;
      else if (clr_status) underflow <= 1'b0;
      if (ofl_set)         overflow  <= 1'b1;
      else if (clr_status) overflow  <= 1'b0;
    end
  end

  assign dout_dr_cc0 = launch_q.dr[0];
  assign dout_dr_cc1 = launch_q.dr[1];
  assign dout_dr_cc2 = launch_q.dr[2];
  assign dout_di_cc0 = launch_q.di[0];
  assign dout_di_cc1 = launch_q.di[1];
  assign dout_di_cc2 = launch_q.di[2];

endmodule

// File: tb/tb_prach_tdm_pack.sv
// Randomized directed bench for prach_tdm_pack against a queue-based slot model.
module tb_prach_tdm_pack;
  localparam int AW      = 3;
  localparam int DEPTH   = 8;
  localparam int PREFILL = 2;

  typedef struct packed {
    logic             sof;
    logic [2:0][15:0] dr;
    logic [2:0][15:0] di;
  } ent_t;

  logic clk;
  logic rst;
  logic clr_status;
  logic [15:0] dout_dr_cc0, dout_dr_cc1, dout_dr_cc2;
  logic [15:0] dout_di_cc0, dout_di_cc1, dout_di_cc2;
  logic [2:0]  dout_chn;
  logic        sync_out, underflow, overflow;
  logic [AW:0] fifo_level;

  prach_tdm_pack_if bus ();

  prach_tdm_pack #(.FIFO_AW(AW), .PREFILL(PREFILL)) dut (
    .clk(clk), .rst(rst), .din(bus), .clr_status(clr_status),
    .dout_dr_cc0(dout_dr_cc0), .dout_dr_cc1(dout_dr_cc1), .dout_dr_cc2(dout_dr_cc2),
    .dout_di_cc0(dout_di_cc0), .dout_di_cc1(dout_di_cc1), .dout_di_cc2(dout_di_cc2),
    .dout_chn(dout_chn), .sync_out(sync_out), .underflow(underflow),
    .overflow(overflow), .fifo_level(fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   sync_cnt;
  int   max_lvl;
  ent_t q[$];
  bit   m_run, m_sync, m_ufl, m_ofl, last_acc;
  logic [2:0]       m_chn;
  logic [2:0][15:0] m_dr, m_di;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_run = 0; m_sync = 0; m_ufl = 0; m_ofl = 0; last_acc = 0;
    m_chn = '0; m_dr = '0; m_di = '0;
  endtask

  task automatic check_all();
    chk("chn",   32'(dout_chn),    32'(m_chn));
    chk("dr0",   32'(dout_dr_cc0), 32'(m_dr[0]));
    chk("dr1",   32'(dout_dr_cc1), 32'(m_dr[1]));
    chk("dr2",   32'(dout_dr_cc2), 32'(m_dr[2]));
    chk("di0",   32'(dout_di_cc0), 32'(m_di[0]));
    chk("di1",   32'(dout_di_cc1), 32'(m_di[1]));
    chk("di2",   32'(dout_di_cc2), 32'(m_di[2]));
    chk("sync",  32'(sync_out),    32'(m_sync));
    chk("ufl",   32'(underflow),   32'(m_ufl));
    chk("ofl",   32'(overflow),    32'(m_ofl));
    chk("level", 32'(fifo_level),  32'(q.size()));
    chk("ready", 32'(bus.din_ready), 32'(!rst && q.size() < DEPTH));
  endtask

  // One clock: apply the slot rules to the queue using pre-edge inputs, then compare.
  task automatic step();
    bit   rdy, ofl_set, ufl_set, launch;
    ent_t e, w;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      rdy      = (q.size() < DEPTH);
      last_acc = bus.din_valid && rdy;
      ofl_set  = bus.din_valid && !rdy;
      ufl_set  = 0;
      w = '{sof: bus.din_sof, dr: bus.din_dr, di: bus.din_di};
      m_sync = 0;
      if (m_chn == 3'd7) begin
        launch = m_run ? (q.size() > 0) : (q.size() >= PREFILL);
        if (launch) begin
          e = q.pop_front();
          m_dr = e.dr; m_di = e.di; m_sync = e.sof; m_run = 1;
        end else begin
          m_dr = '0; m_di = '0;
          if (m_run) begin ufl_set = 1; m_run = 0; end
        end
      end
      if (last_acc) q.push_back(w);
      m_ufl = ufl_set ? 1'b1 : (clr_status ? 1'b0 : m_ufl);
      m_ofl = ofl_set ? 1'b1 : (clr_status ? 1'b0 : m_ofl);
      m_chn = m_chn + 3'd1;
    end
    #1;
    if (sync_out) sync_cnt++;
    if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
    check_all();
  endtask

  task automatic idle(int n);
    bus.din_valid = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_chn(logic [2:0] c);
    for (int i = 0; i < 8 && m_chn != c; i++) step();
  endtask

  task automatic rnd_sample(logic [15:0] dr0, bit sof);
    bus.din_dr[0] = dr0;
    bus.din_dr[1] = 16'($urandom);
    bus.din_dr[2] = 16'($urandom);
    bus.din_di[0] = 16'($urandom);
    bus.din_di[1] = 16'($urandom);
    bus.din_di[2] = 16'($urandom);
    bus.din_sof   = sof;
  endtask

  initial begin
    bit found;
    int rate;
    rst = 1; clr_status = 0;
    bus.din_valid = 0; bus.din_sof = 0; bus.din_dr = '0; bus.din_di = '0;
    model_reset();
    for (int i = 0; i < 3; i++) step();
    rst = 0;
    idle(20);

    // steady stream, one sample per slot, sof on the first
    sync_cnt = 0;
    for (int i = 1; i <= 10; i++) begin
      wait_chn(3'd3);
      rnd_sample(16'(i), i == 1);
      bus.din_valid = 1;
      step();
      bus.din_valid = 0;
    end
    idle(48);
    chk("sync_once", 32'(sync_cnt), 32'd1);
    chk("starve_ufl", 32'(underflow), 32'd1);
    clr_status = 1; step(); clr_status = 0;
    chk("clr_ufl", 32'(underflow), 32'd0);

    // write landing in the chn==7 cycle at level PREFILL-1
    wait_chn(3'd5);
    rnd_sample(16'h0B0B, 0); bus.din_valid = 1; step();
    bus.din_valid = 0; step();
    rnd_sample(16'h0C0C, 0); bus.din_valid = 1; step();
    bus.din_valid = 0;
    chk("bnd_nolaunch", 32'(dout_dr_cc0), 32'd0);
    idle(8);
    chk("bnd_launch", 32'(dout_dr_cc0), 32'h0B0B);
    idle(32);
    clr_status = 1; step(); clr_status = 0;

    // burst until full with upstream holding on backpressure
    max_lvl = 0;
    rnd_sample(16'($urandom), 1);
    bus.din_valid = 1;
    for (int i = 0; i < 24; i++) begin
      step();
      if (last_acc) rnd_sample(16'($urandom), 0);
    end
    for (int i = 0; i < 50 && !last_acc; i++) step();
    bus.din_valid = 0;
    chk("burst_full", 32'(max_lvl), 32'd8);
    chk("burst_ofl", 32'(overflow), 32'd1);
    idle(100);
    clr_status = 1; step(); clr_status = 0;

    // random traffic at varying rates
    for (int c = 0; c < 6; c++) begin
      rate = $urandom_range(1, 4);
      for (int k = 0; k < 64; k++) begin
        if (!(bus.din_valid && !last_acc)) begin
          bus.din_valid = ($urandom_range(0, (1 << rate) - 1) == 0);
          if (bus.din_valid) rnd_sample(16'($urandom), $urandom_range(0, 3) == 0);
        end
        clr_status = ($urandom_range(0, 31) == 0);
        step();
      end
    end
    clr_status = 0;
    for (int i = 0; i < 50 && bus.din_valid && !last_acc; i++) step();
    bus.din_valid = 0;
    idle(8);

    // reach RUN with five entries, then reset asynchronously mid-cycle
    found = 0;
    for (int n = 0; n < 300; n++) begin
      if (m_run && q.size() == 5) begin found = 1; break; end
      bus.din_valid = (q.size() < 5);
      if (bus.din_valid) rnd_sample(16'($urandom), $urandom_range(0, 1) == 0);
      step();
    end
    bus.din_valid = 0;
    chk("mid_setup", 32'(found), 32'd1);
    #2;
    rst = 1;
    #1;
    model_reset();
    check_all();
    step(); step();
    rst = 0;
    idle(12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
